fft_operand_sequencer: RTL and testbench
========================================

// Module: fft_operand_sequencer
// PURPOSE
//  Control stage directly upstream of the radix-2 butterfly. Walks an in-place N-point radix-2 DIT FFT
//  over a dual-read sample RAM and a twiddle ROM, and presents x_N/x_M/w_N with a valid strobe.
//  Also emits write-back addresses delayed to line up with the butterfly's 2-cycle y_N/y_M output.
//  Sample RAM is pre-loaded in bit-reversed order; this block performs no reordering.
// PARAMETERS
//  DATA_WIDTH   16  operand/twiddle word width, matches butterfly
//  LOG2_N       8   log2 of FFT length N (N = 1<<LOG2_N), legal range 2..12
//  MEM_RD_LAT   1   read latency (cycles) of sample RAM and twiddle ROM, >=1
//  BFLY_LAT     2   butterfly input-to-output latency (cycles)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  start      in   1             1-cycle pulse: begin a transform (ignored while busy)
//  busy       out  1             high from cycle after accepted start until done
//  done       out  1             1-cycle pulse after final write-back of last stage
//  rd_en      out  1             sample RAM / twiddle ROM read strobe
//  rd_addr_n  out  LOG2_N        upper-leg read address
//  rd_addr_m  out  LOG2_N        lower-leg read address
//  tw_addr    out  LOG2_N-1      twiddle ROM address
//  rd_data_n  in   DATA_WIDTH    RAM data for rd_addr_n, MEM_RD_LAT after rd_en
//  rd_data_m  in   DATA_WIDTH    RAM data for rd_addr_m, MEM_RD_LAT after rd_en
//  tw_data    in   DATA_WIDTH    ROM data for tw_addr, MEM_RD_LAT after rd_en
//  x_N,x_M,w_N out DATA_WIDTH    butterfly operands (combinational pass of rd_data_n/m, tw_data)
//  op_valid   out  1             operands valid (rd_en delayed MEM_RD_LAT)
//  wr_en      out  1             write-back strobe for y_N/y_M (rd_en delayed L = MEM_RD_LAT+BFLY_LAT)
//  wr_addr_n  out  LOG2_N        write address for y_N (rd_addr_n delayed L)
//  wr_addr_m  out  LOG2_N        write address for y_M (rd_addr_m delayed L)
// BEHAVIOUR
//  Reset: state IDLE, counters 0; busy, done, rd_en, op_valid, wr_en, all addresses = 0.
//  Reset mid-transform aborts immediately; in-flight delay-line entries discarded (no wr_en after reset).
//  FSM: IDLE -start-> ISSUE; ISSUE -(k==N/2-1)-> DRAIN; DRAIN -(cnt==L-1, s<LOG2_N-1)-> ISSUE with s+1, k=0;
//   DRAIN -(cnt==L-1, s==LOG2_N-1)-> DONE; DONE -> IDLE (1 cycle, done=1).
//  ISSUE: rd_en=1 every cycle, one butterfly per cycle, k = 0..N/2-1 within stage s = 0..LOG2_N-1.
//  Addressing (half = 1<<s, j = k & (half-1), g = k>>s):
//   rd_addr_n = (g << (s+1)) | j;  rd_addr_m = rd_addr_n + half;  tw_addr = j << (LOG2_N-1-s).
//  DRAIN: rd_en=0 for exactly L cycles so last stage-s write lands before first stage-s+1 read
//   (RAM write visible to a read issued the following cycle).
//  Delay lines: op_valid and wr_en/wr_addr_* are shift registers of rd_en/rd_addr_*; no stalls, no backpressure.
//  busy=1 in ISSUE, DRAIN; 0 in IDLE, DONE. done high only in DONE.
//  start while busy or in DONE: ignored. start same cycle as reset release: ignored.
//  Total: accepted start at cycle 0 -> first rd_en cycle 1 -> done at cycle 1 + LOG2_N*(N/2+L).
//  No arithmetic on data; x/w operands pass through unmodified (width DATA_WIDTH).
// TESTING
//  LOG2_N=3, L=3, start: stage0 pairs (0,1,tw0)(2,3,0)(4,5,0)(6,7,0) on consecutive rd_en cycles.
//  Same run: stage1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage2 (0,4,0)(1,5,1)(2,6,2)(3,7,3); 3 idle cycles between stages.
//  Same run: wr_en/wr_addr_* reproduce rd pattern exactly 3 cycles later; done pulses once at cycle 22, busy drops then.
//  RAM model returns addr as data: op_valid high exactly 1 cycle after rd_en with x_N=rd_addr_n, x_M=rd_addr_m.
//  start pulsed again at cycle 5 and in DONE cycle -> ignored, sequence unchanged, single done.
//  rst_n low at cycle 10 mid-stage1 -> all outputs 0 asynchronously, no wr_en after; new start runs full clean transform.

Source files
------------

// File: rtl/fft_operand_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: walks stages and butterflies,
// issues dual reads plus twiddle reads, and delays the addresses to line up with butterfly write-back.
module fft_operand_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_N     = 8,
    parameter int MEM_RD_LAT = 1,
    parameter int BFLY_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [LOG2_N-1:0]     rd_addr_n,
    output logic [LOG2_N-1:0]     rd_addr_m,
    output logic [LOG2_N-2:0]     tw_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_n,
    input  logic [DATA_WIDTH-1:0] rd_data_m,
    input  logic [DATA_WIDTH-1:0] tw_data,
    output logic [DATA_WIDTH-1:0] x_N,
    output logic [DATA_WIDTH-1:0] x_M,
    output logic [DATA_WIDTH-1:0] w_N,
    output logic                  op_valid,
    output logic                  wr_en,
    output logic [LOG2_N-1:0]     wr_addr_n,
    output logic [LOG2_N-1:0]     wr_addr_m
);

    localparam int L   = MEM_RD_LAT + BFLY_LAT;
    localparam int K_W = LOG2_N - 1;
    localparam int S_W = $clog2(LOG2_N);
    localparam int C_W = $clog2(L);

    localparam logic [K_W-1:0] K_LAST = '1;
    localparam logic [S_W-1:0] S_LAST = S_W'(LOG2_N - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(L - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [K_W-1:0] r_k,     w_k_nxt;
    logic [S_W-1:0] r_s,     w_s_nxt;
    logic [C_W-1:0] r_cnt,   w_cnt_nxt;
    logic           r_armed;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= 1'b1;
        end
    end

    // r_armed blocks a start that arrives on the first edge after reset release.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start && r_armed) begin
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = '0;
                    w_s_nxt     = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ISSUE: begin
                w_k_nxt = r_k + 1'b1;
                if (r_k == K_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_s == S_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_s_nxt     = r_s + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = '0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Butterfly k of stage s: j = position inside the group, g = group index.
    logic [K_W-1:0]    w_mask, w_j, w_g, w_tw;
    logic [LOG2_N-1:0] w_half, w_addr_n;

    assign w_mask   = ~({K_W{1'b1}} << r_s);
    assign w_j      = r_k & w_mask;
    assign w_g      = r_k >> r_s;
    assign w_half   = {{K_W{1'b0}}, 1'b1} << r_s;
    assign w_addr_n = (({1'b0, w_g} << r_s) << 1) | {1'b0, w_j};
    assign w_tw     = w_j << (S_LAST - r_s);

    assign busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign rd_en     = (r_state == ST_ISSUE);
    assign rd_addr_n = rd_en ? w_addr_n          : '0;
    assign rd_addr_m = rd_en ? w_addr_n + w_half : '0;
    assign tw_addr   = rd_en ? w_tw              : '0;

    assign x_N = rd_data_n;
    assign x_M = rd_data_m;
    assign w_N = tw_data;

    logic [L-1:0]      r_vld_sr;
    logic [LOG2_N-1:0] r_an_sr [L];
    logic [LOG2_N-1:0] r_am_sr [L];

    // NOTE: the delay lines are reset so an aborted transform can never emit a stray write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr <= '0;
            for (int i = 0; i < L; i++) begin
                r_an_sr[i] <= '0;
                r_am_sr[i] <= '0;
            end
        end else begin
            r_vld_sr   <= {r_vld_sr[L-2:0], rd_en};
            r_an_sr[0] <= rd_addr_n;
            r_am_sr[0] <= rd_addr_m;
            for (int i = 1; i < L; i++) begin
                r_an_sr[i] <= r_an_sr[i-1];
                r_am_sr[i] <= r_am_sr[i-1];
            end
        end
    end

    assign op_valid  = r_vld_sr[MEM_RD_LAT-1];
    assign wr_en     = r_vld_sr[L-1];
    assign wr_addr_n = r_an_sr[L-1];
    assign wr_addr_m = r_am_sr[L-1];

endmodule

// File: tb/tb_fft_operand_sequencer.sv
// Bench for fft_operand_sequencer at N=8, L=3: schedule model per cycle after start, plus literal pins.
module tb_fft_operand_sequencer;

    localparam int LOG2_N   = 3;
    localparam int N        = 1 << LOG2_N;
    localparam int DW       = 16;
    localparam int MRL      = 1;
    localparam int BL       = 2;
    localparam int L        = MRL + BL;
    localparam int DONE_REL = 1 + LOG2_N * (N / 2 + L);

    logic            clk, rst_n, start;
    logic            busy, done, rd_en, op_valid, wr_en;
    logic [2:0]      rd_addr_n, rd_addr_m, wr_addr_n, wr_addr_m;
    logic [1:0]      tw_addr;
    logic [DW-1:0]   rd_data_n, rd_data_m, tw_data, x_N, x_M, w_N;

    fft_operand_sequencer #(
        .DATA_WIDTH(DW), .LOG2_N(LOG2_N), .MEM_RD_LAT(MRL), .BFLY_LAT(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_n(rd_addr_n), .rd_addr_m(rd_addr_m), .tw_addr(tw_addr),
        .rd_data_n(rd_data_n), .rd_data_m(rd_data_m), .tw_data(tw_data),
        .x_N(x_N), .x_M(x_M), .w_N(w_N), .op_valid(op_valid),
        .wr_en(wr_en), .wr_addr_n(wr_addr_n), .wr_addr_m(wr_addr_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memories return their address as data, one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_n <= DW'(rd_addr_n);
            rd_data_m <= DW'(rd_addr_m);
            tw_data   <= DW'(tw_addr);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name, input int target);
        n_checks++;
        $display("FAIL %s: timed out, got no cycle reaching %0d", name, target);
    endtask

    // Expected schedule indexed by cycle number after the accepted start (cycle 1 = first read).
    int m_rd [0:DONE_REL];
    int m_an [0:DONE_REL];
    int m_am [0:DONE_REL];
    int m_tw [0:DONE_REL];

    int rel     = -1;
    bit m_armed = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel     <= -1;
            m_armed <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            if (rel >= 1)               rel <= (rel == DONE_REL) ? -1 : rel + 1;
            else if (start && m_armed)  rel <= 1;
        end
    end

    function automatic int sched(input int idx, input int which);
        if (idx < 1 || idx > DONE_REL) return 0;
        case (which)
            0:       return m_rd[idx];
            1:       return m_an[idx];
            2:       return m_am[idx];
            default: return m_tw[idx];
        endcase
    endfunction

    int           done_cnt      = 0;
    int           done_rel_seen = -1;
    int           run_no        = 0;
    logic [7:0]   rd_q [$];

    always @(negedge clk) begin
        int r_ov, r_wr;
        logic [4:0] e_ctrl;
        r_ov = (rel >= 1) ? rel - MRL : 0;
        r_wr = (rel >= 1) ? rel - L   : 0;
        e_ctrl = {rel >= 1 && rel < DONE_REL, rel == DONE_REL, sched(rel, 0) != 0,
                  sched(r_ov, 0) != 0, sched(r_wr, 0) != 0};
        check("ctrl{busy,done,rd_en,op_valid,wr_en}", {busy, done, rd_en, op_valid, wr_en}, e_ctrl);
        check("rd_addr{n,m,tw}", {rd_addr_n, rd_addr_m, tw_addr},
              {3'(sched(rel, 1)), 3'(sched(rel, 2)), 2'(sched(rel, 3))});
        check("wr_addr{n,m}", {wr_addr_n, wr_addr_m},
              {3'(sched(r_wr, 1)), 3'(sched(r_wr, 2))});
        if (sched(r_ov, 0) != 0)
            check("operands{x_N,x_M,w_N}", {x_N, x_M, w_N},
                  {DW'(sched(r_ov, 1)), DW'(sched(r_ov, 2)), DW'(sched(r_ov, 3))});
        if (done) begin
            done_cnt++;
            done_rel_seen = rel;
        end
        if (rd_en && run_no == 1) rd_q.push_back({rd_addr_n, rd_addr_m, tw_addr});
    end

    int lit_tab [12][3] = '{
        '{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
        '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
        '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}
    };

    task automatic wait_rel(input int target, input int max_cycles);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            @(negedge clk);
            if (rel == target) found = 1'b1;
        end
        if (!found) timeout_fail("wait_rel", target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        start = 1'b0;

        for (int i = 0; i <= DONE_REL; i++) begin
            m_rd[i] = 0; m_an[i] = 0; m_am[i] = 0; m_tw[i] = 0;
        end
        r = 1;
        for (int s = 0; s < LOG2_N; s++) begin
            int half, span;
            half = 1 << s;
            span = 2 * half;
            for (int g = 0; g < N / span; g++) begin
                for (int j = 0; j < half; j++) begin
                    m_rd[r] = 1;
                    m_an[r] = g * span + j;
                    m_am[r] = g * span + j + half;
                    m_tw[r] = j * (N / span);
                    r++;
                end
            end
            r += L;
        end
        check("model_done_cycle", r, 22);
        for (int i = 0; i < 12; i++) begin
            int c;
            c = 1 + (i / 4) * (N / 2 + L) + (i % 4);
            check("model_pair", {m_an[c], m_am[c], m_tw[c]},
                  {lit_tab[i][0], lit_tab[i][1], lit_tab[i][2]});
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, rd_en, op_valid, wr_en, rd_addr_n, rd_addr_m,
                                tw_addr, wr_addr_n, wr_addr_m}, 0);

        // Start coinciding with reset release must be ignored.
        rst_n = 1'b1;
        pulse_start();
        repeat (2) @(negedge clk);
        check("start_at_release_ignored", busy, 1'b0);

        run_no = 1;
        pulse_start();
        wait_rel(5, 10);
        pulse_start();
        wait_rel(DONE_REL, 40);
        pulse_start();
        repeat (4) @(negedge clk);
        run_no = 0;
        check("run1_done_count", done_cnt, 1);
        check("run1_done_cycle", done_rel_seen, 22);
        check("run1_read_count", rd_q.size(), 12);
        for (int i = 0; i < 12 && i < rd_q.size(); i++)
            check("run1_read_pair", rd_q[i], {3'(lit_tab[i][0]), 3'(lit_tab[i][1]), 2'(lit_tab[i][2])});

        // Abort mid stage 1 with an asynchronous reset.
        pulse_start();
        wait_rel(9, 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_clears", {busy, done, rd_en, op_valid, wr_en, rd_addr_n,
                                        rd_addr_m, tw_addr, wr_addr_n, wr_addr_m}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt, 1);

        pulse_start();
        wait_rel(DONE_REL, 40);
        repeat (4) @(negedge clk);
        check("run3_done_count", done_cnt, 2);
        check("run3_done_cycle", done_rel_seen, 22);
        check("idle_after_run", {busy, rd_en, wr_en}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
